// File: rtl/pixel_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pixel_fetch_pkg
// Shared definitions for the pixel fetch DMA:
//   state_t       - job FSM states
//   REG_*         - slave register addresses
//   CTRL_/STAT_*  - bit positions in the CTRL (write) and STATUS (read) word
// -----------------------------------------------------------------------------
package pixel_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

   localparam logic [1:0] REG_CTRL      = 2'd0;
   localparam logic [1:0] REG_SRC_ADDR  = 2'd1;
   localparam logic [1:0] REG_LENGTH    = 2'd2;
   localparam logic [1:0] REG_DELIVERED = 2'd3;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;
   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_DONE_BIT  = 1;

endpackage

// File: rtl/pixel_fetch_dma_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with flush, used as the stream buffer of pixel_fetch_dma.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_flush           empties the FIFO (wins over push/pop in the same cycle)
//   i_push, i_data    write side; a push on a full FIFO only lands if a pop
//                     happens in the same cycle
//   i_pop             read side; ignored while empty
//   o_data            head word (0 while empty)
//   o_full, o_empty   status flags
//   o_count           number of stored words
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   // Gate the head so the stream data reads 0 whenever nothing is buffered.
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_fetch_dma.sv
// -----------------------------------------------------------------------------
// pixel_fetch_dma
// Reads LENGTH 32-bit words from SDRAM starting at SRC_ADDR (single-word
// pipelined Avalon-MM reads) and streams them to the compression core.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   addr/rd_en/wr_en/writedata   Avalon-MM slave (CTRL, SRC_ADDR, LENGTH,
//   readdata                     DELIVERED); readdata registered, 1-cycle latency
//   master_*                     Avalon-MM read master to SDRAM (write tied off)
//   out_valid/out_ready/         pixel stream; out_last marks the final word
//   out_data/out_last
//   dbg_state                    current FSM state (state_t encoding)
//
// Stream handshake: a word transfers on every clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_last stay
// stable until that transfer; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module pixel_fetch_dma
   import pixel_fetch_pkg::*;
#(
   parameter int FIFO_DEPTH      = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int LEN_W           = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        master_waitrequest,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid,
   output logic [31:0] master_address,
   output logic        master_read,
   output logic        master_write,
   output logic [31:0] master_writedata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic [2:0]  dbg_state
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int SW  = ((FCW > OW) ? FCW : OW) + 1;

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_src_addr;
   logic [LEN_W-1:0] r_length;
   logic [LEN_W-1:0] r_delivered;
   logic [LEN_W-1:0] r_issued;
   logic [OW-1:0]    r_outstanding;
   logic [31:0]      r_addr_ptr;
   logic             r_done;
   logic             r_req_pending;
   logic [31:0]      r_readdata;

   logic             w_ctrl_wr;
   logic             w_start;
   logic             w_abort;
   logic             w_launch;
   logic             w_flush;
   logic             w_master_read;
   logic             w_issue_ok;
   logic             w_accept;
   logic             w_ret;
   logic             w_push;
   logic             w_pop;
   logic             w_busy;
   logic [SW-1:0]    w_credit_sum;
   logic [FCW-1:0]   w_fifo_count;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [31:0]      w_fifo_data;

   assign w_ctrl_wr = wr_en && (addr == REG_CTRL);
   assign w_start   = w_ctrl_wr && writedata[CTRL_START_BIT];
   assign w_abort   = w_ctrl_wr && writedata[CTRL_ABORT_BIT];
   assign w_busy    = (r_state != ST_IDLE);

   // Words already buffered plus reads still in flight must fit in the FIFO,
   // so every returning word is guaranteed a slot.
   assign w_credit_sum = SW'(w_fifo_count) + SW'(r_outstanding);
   assign w_issue_ok   = (r_issued < r_length)
                      && (r_outstanding < OW'(MAX_OUTSTANDING))
                      && (w_credit_sum < SW'(FIFO_DEPTH));

   assign w_accept = w_master_read && !master_waitrequest;
   // Data arriving with nothing outstanding (e.g. after a reset) is stale.
   assign w_ret    = master_readdatavalid && (r_outstanding != '0);
   assign w_push   = w_ret && (r_state != ST_ABORT);
   assign w_pop    = out_valid && out_ready;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      w_master_read = 1'b0;
      w_flush       = 1'b0;
      w_launch      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_launch     = 1'b1;
               w_next_state = (r_length == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_master_read = w_issue_ok;
            if (w_abort) begin
               w_next_state = ST_ABORT;
               w_flush      = 1'b1;
            end else if (r_issued == r_length) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_abort) begin
               w_next_state = ST_ABORT;
               w_flush      = 1'b1;
            end else if (r_delivered == r_length) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         ST_ABORT: begin
            // A request caught in a stall must be held until the slave takes
            // it; its data is then awaited and dropped like the others.
            w_master_read = r_req_pending;
            w_flush       = 1'b1;
            if ((r_outstanding == '0) && !r_req_pending) w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------- job counters ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_ptr    <= '0;
         r_issued      <= '0;
         r_outstanding <= '0;
         r_delivered   <= '0;
         r_done        <= 1'b0;
         r_req_pending <= 1'b0;
      end else begin
         r_req_pending <= w_master_read && master_waitrequest;
         if (w_launch) begin
            r_addr_ptr    <= r_src_addr;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_delivered   <= '0;
            r_done        <= 1'b0;
         end else begin
            if (w_accept) begin
               r_addr_ptr <= r_addr_ptr + 32'd4;
               r_issued   <= r_issued + 1'b1;
            end
            case ({w_accept, w_ret})
               2'b10:   r_outstanding <= r_outstanding + 1'b1;
               2'b01:   r_outstanding <= r_outstanding - 1'b1;
               default: r_outstanding <= r_outstanding;
            endcase
            if (w_pop) r_delivered <= r_delivered + 1'b1;
            if (r_state == ST_DONE) r_done <= 1'b1;
         end
      end
   end

   // ---------------- slave registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src_addr <= '0;
         r_length   <= '0;
      end else if (wr_en && !w_busy) begin
         if (addr == REG_SRC_ADDR) r_src_addr <= {writedata[31:2], 2'b00};
         if (addr == REG_LENGTH)   r_length   <= writedata[LEN_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else if (rd_en) begin
         case (addr)
            REG_CTRL: begin
               r_readdata                <= '0;
               r_readdata[STAT_BUSY_BIT] <= w_busy;
               r_readdata[STAT_DONE_BIT] <= r_done;
            end
            REG_SRC_ADDR:  r_readdata <= r_src_addr;
            REG_LENGTH:    r_readdata <= {{(32-LEN_W){1'b0}}, r_length};
            default:       r_readdata <= {{(32-LEN_W){1'b0}}, r_delivered};
         endcase
      end
   end

   // ---------------- stream buffer ----------------
   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (master_readdata),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_push && w_fifo_full && !w_pop && !w_flush));

   assign readdata         = r_readdata;
   assign master_read      = w_master_read;
   assign master_address   = r_addr_ptr;
   assign master_write     = 1'b0;
   assign master_writedata = '0;
   assign out_valid        = !w_fifo_empty;
   assign out_data         = w_fifo_data;
   assign out_last         = out_valid && (r_delivered == (r_length - LEN_W'(1)));
   assign dbg_state        = r_state;

endmodule
